// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder definitions: prefix/control byte constants, FSM states, event payload.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    localparam logic [7:0] PS2_CTL_NUL    = 8'h00;
    localparam logic [7:0] PS2_CTL_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_CTL_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_CTL_ACK    = 8'hFA;
    localparam logic [7:0] PS2_CTL_BAT_FC = 8'hFC;
    localparam logic [7:0] PS2_CTL_BAT_FD = 8'hFD;
    localparam logic [7:0] PS2_CTL_RESEND = 8'hFE;
    localparam logic [7:0] PS2_CTL_ERR    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == PS2_CTL_NUL)    || (b == PS2_CTL_BAT_OK) ||
               (b == PS2_CTL_ECHO)   || (b == PS2_CTL_ACK)    ||
               (b == PS2_CTL_BAT_FC) || (b == PS2_CTL_BAT_FD) ||
               (b == PS2_CTL_RESEND) || (b == PS2_CTL_ERR);
    endfunction

    function automatic logic is_pfx(input logic [7:0] b);
        return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with registered head outputs; wrap pointers carry an extra bit
// so full and empty are distinguishable.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  ps2_evt_t din,
    input  logic     ready,
    output ps2_evt_t dout,
    output logic     valid,
    output logic     drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    ps2_evt_t        mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     wr_ptr_n;
    logic [AW:0]     rd_ptr_n;
    logic            pop_c;
    logic            full_c;
    logic            wr_en_c;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_c    = valid && ready;
        full_c   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        wr_en_c  = push && (!full_c || pop_c);
        drop_c   = push && full_c && !pop_c;
        wr_ptr_n = wr_ptr + (AW+1)'(wr_en_c);
        rd_ptr_n = rd_ptr + (AW+1)'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Head register bypasses the array when the entry being written becomes the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            valid  <= (wr_ptr_n != rd_ptr_n);
            if (wr_en_c && (wr_ptr == rd_ptr_n)) begin
                dout <= din;
            end else begin
                dout <= mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code set 2 decoder with prefix timeout, event FIFO and sticky overflow.
// Optional typematic repeat filter enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       overflow,
    input  logic       clr_ovf,
    output logic       proto_err
);

    localparam int unsigned TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    ps2_state_e    state;
    ps2_state_e    state_n;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_c;
    logic          emit_c;
    logic          keep_c;
    logic          perr_c;
    ps2_evt_t      evt_c;
    logic          push_q;
    ps2_evt_t      push_evt;
    ps2_evt_t      head;
    logic          drop_c;

    // Byte decode: control bytes abort any sequence; a byte beats a coincident timeout.
    always_comb begin
        state_n = state;
        emit_c  = 1'b0;
        perr_c  = 1'b0;
        evt_c   = '0;
        tmo_c   = (state != ST_IDLE) && (tmo_cnt == TMO_MAX);
        if (rx_valid) begin
            if (is_ctrl(rx_byte)) begin
                state_n = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == PS2_PFX_EXT) begin
                            state_n = ST_GOT_E0;
                        end else if (rx_byte == PS2_PFX_BRK) begin
                            state_n = ST_GOT_F0;
                        end else begin
                            emit_c = 1'b1;
                            evt_c  = '{ext: 1'b0, brk: 1'b0, code: rx_byte};
                        end
                    end
                    ST_GOT_E0: begin
                        if (rx_byte == PS2_PFX_BRK) begin
                            state_n = ST_GOT_E0F0;
                        end else if (rx_byte != PS2_PFX_EXT) begin
                            state_n = ST_IDLE;
                            emit_c  = 1'b1;
                            evt_c   = '{ext: 1'b1, brk: 1'b0, code: rx_byte};
                        end
                    end
                    ST_GOT_F0, ST_GOT_E0F0: begin
                        state_n = ST_IDLE;
                        if (is_pfx(rx_byte)) begin
                            perr_c = 1'b1;
                        end else begin
                            emit_c = 1'b1;
                            evt_c  = '{ext: (state == ST_GOT_E0F0), brk: 1'b1, code: rx_byte};
                        end
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end else if (tmo_c) begin
            state_n = ST_IDLE;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       held_v;
    logic       held_ext;
    logic [7:0] held_code;
    logic       held_hit_c;

    // Repeated makes of the held key are typematic and suppressed.
    always_comb begin
        held_hit_c = held_v && (held_code == evt_c.code) && (held_ext == evt_c.ext);
        keep_c     = emit_c && !(!evt_c.brk && held_hit_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_v    <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= 8'h00;
        end else if (emit_c) begin
            if (!evt_c.brk) begin
                held_v    <= 1'b1;
                held_ext  <= evt_c.ext;
                held_code <= evt_c.code;
            end else if (held_hit_c) begin
                held_v <= 1'b0;
            end
        end
    end
`else
    assign keep_c = emit_c;
`endif

    // State, saturating prefix timer, event stage register and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            push_q    <= 1'b0;
            push_evt  <= '0;
            proto_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_n;
            if (rx_valid) begin
                tmo_cnt <= '0;
            end else if ((state != ST_IDLE) && (tmo_cnt != TMO_MAX)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            push_q    <= keep_c;
            push_evt  <= evt_c;
            proto_err <= perr_c;
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push_q),
        .din    (push_evt),
        .ready  (evt_ready),
        .dout   (head),
        .valid  (evt_valid),
        .drop_c (drop_c)
    );

    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: queue-based reference model plus directed literal checks.
// Expectations follow PS2_REPEAT_FILTER_EN when it is defined for the build.
module tb_ps2_scan_sequencer;
    import ps2_pkg::*;

    localparam int unsigned D = 4;
    localparam int unsigned T = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic       overflow;
    logic       clr_ovf = 1'b0;
    logic       proto_err;

    int checks = 0;
    int failures = 0;

    ps2_scan_sequencer #(.FIFO_DEPTH(D), .TIMEOUT_CYC(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: event list semantics in terms of byte history and cycle indices.
    logic [9:0] m_q[$];
    logic       m_stage_v;
    logic [9:0] m_stage;
    logic       m_ovf;
    logic       m_perr;
    logic       m_pend;
    logic       m_pext;
    logic       m_pbrk;
    int         m_cyc;
    int         m_last;
    logic       m_hv;
    logic [8:0] m_held;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_stage_v = 1'b0;
            m_stage   = '0;
            m_ovf     = 1'b0;
            m_perr    = 1'b0;
            m_pend    = 1'b0;
            m_pext    = 1'b0;
            m_pbrk    = 1'b0;
            m_cyc     = 0;
            m_last    = 0;
            m_hv      = 1'b0;
            m_held    = '0;
        end else begin
            logic pop, set, emit, live;
            logic [9:0] e;
            pop = (m_q.size() != 0) && evt_ready;
            if (pop) void'(m_q.pop_front());
            set = 1'b0;
            if (m_stage_v) begin
                if (m_q.size() < D) m_q.push_back(m_stage);
                else set = 1'b1;
            end
            if (set) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_perr = 1'b0;
            emit = 1'b0;
            e = '0;
            if (rx_valid) begin
                live = m_pend && ((m_cyc - m_last) < int'(T + 2));
                m_last = m_cyc;
                if (is_ctrl(rx_byte)) begin
                    m_pend = 1'b0;
                end else if (!live) begin
                    m_pext = 1'b0;
                    m_pbrk = 1'b0;
                    m_pend = 1'b0;
                    if (rx_byte == 8'hE0) begin m_pend = 1'b1; m_pext = 1'b1; end
                    else if (rx_byte == 8'hF0) begin m_pend = 1'b1; m_pbrk = 1'b1; end
                    else begin emit = 1'b1; e = {2'b00, rx_byte}; end
                end else if (m_pbrk) begin
                    m_pend = 1'b0;
                    if (rx_byte == 8'hE0 || rx_byte == 8'hF0) m_perr = 1'b1;
                    else begin emit = 1'b1; e = {m_pext, 1'b1, rx_byte}; end
                end else begin
                    if (rx_byte == 8'hF0) m_pbrk = 1'b1;
                    else if (rx_byte != 8'hE0) begin
                        m_pend = 1'b0;
                        emit = 1'b1;
                        e = {2'b10, rx_byte};
                    end
                end
            end
`ifdef PS2_REPEAT_FILTER_EN
            if (emit) begin
                if (!e[8]) begin
                    if (m_hv && m_held == {e[9], e[7:0]}) emit = 1'b0;
                    else begin m_hv = 1'b1; m_held = {e[9], e[7:0]}; end
                end else if (m_hv && m_held == {e[9], e[7:0]}) begin
                    m_hv = 1'b0;
                end
            end
`endif
            m_stage_v = emit;
            m_stage   = e;
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("model_valid", 32'(evt_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0)
                check("model_head", 32'({evt_ext, evt_break, evt_code}), 32'(m_q[0]));
            check("model_ovf", 32'(overflow), 32'(m_ovf));
            check("model_perr", 32'(proto_err), 32'(m_perr));
        end
    end

    // Consumed-event log and proto_err pulse counter for literal checks.
    logic [9:0] log_q[$];
    int pe_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (evt_valid && evt_ready) log_q.push_back({evt_ext, evt_break, evt_code});
            if (proto_err) pe_cnt++;
        end
    end

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_log(input string name, input logic [9:0] exp[$]);
        check({name, "_count"}, 32'(log_q.size()), 32'(exp.size()));
        if (log_q.size() == exp.size())
            foreach (exp[i]) check({name, "_evt"}, 32'(log_q[i]), 32'(exp[i]));
    endtask

    logic [7:0] burst [16] = '{8'hE0, 8'h1C, 8'hF0, 8'hE0, 8'hE0, 8'hE0, 8'h71, 8'hFA,
                               8'hE0, 8'hF0, 8'hE0, 8'h12, 8'hF0, 8'h12, 8'h00, 8'h5A};

    initial begin
        idle(3);
        @(negedge clk);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_code", 32'(evt_code), 32'h00);
        check("rst_flags", 32'({evt_ext, evt_break, overflow, proto_err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        // Single make and its latency.
        send(8'h1C);
        @(negedge clk);
        check("lat_n1_valid", 32'(evt_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_n2_valid", 32'(evt_valid), 32'd1);
        check("lat_n2_evt", 32'({evt_ext, evt_break, evt_code}), 32'h01C);
        @(posedge clk); #1;
        evt_ready = 1'b1;
        send(8'hF0); send(8'h1C);
        idle(4);

        // Extended break.
        log_q.delete(); pe_cnt = 0;
        send(8'hE0); send(8'hF0); send(8'h75);
        idle(4);
        expect_log("ext_brk", '{10'h375});
        check("ext_brk_perr", 32'(pe_cnt), 32'd0);

        // Illegal prefix pair, then recovery.
        log_q.delete(); pe_cnt = 0;
        send(8'hF0); send(8'hE0);
        idle(3);
        check("perr_pulses", 32'(pe_cnt), 32'd1);
        check("perr_no_evt", 32'(log_q.size()), 32'd0);
        send(8'h1C);
        idle(4);
        expect_log("perr_recover", '{10'h01C});

        // Prefix timeout and the cycle just inside it.
        log_q.delete();
        send(8'hE0); idle(T + 2); send(8'h74);
        idle(4);
        send(8'hE0); idle(T - 1); send(8'h74);
        idle(4);
        expect_log("timeout", '{10'h074, 10'h274});

        // Control byte aborts a pending break silently.
        log_q.delete(); pe_cnt = 0;
        send(8'hF0); send(8'hAA); send(8'h2C);
        idle(4);
        expect_log("ctrl_abort", '{10'h02C});
        check("ctrl_perr", 32'(pe_cnt), 32'd0);

        // Overflow with a stalled consumer.
        evt_ready = 1'b0;
        log_q.delete();
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
        idle(3);
        check("ovf_set", 32'(overflow), 32'd1);
        clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_clr", 32'(overflow), 32'd0);
        check("ovf_head", 32'({evt_ext, evt_break, evt_code}), 32'h010);
        @(posedge clk); #1;
        send(8'h15);
        clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        @(posedge clk); #1;
        clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
        evt_ready = 1'b1;
        idle(8);
        expect_log("ovf_drain", '{10'h010, 10'h011, 10'h012, 10'h013});

        // Mixed burst with a throttled consumer, checked by the model.
        for (int i = 0; i < 16; i++) begin
            evt_ready = (i % 3) != 0;
            send(burst[i]);
        end
        evt_ready = 1'b1;
        idle(8);

        // Typematic repeat sequence.
        log_q.delete();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        idle(6);
`ifdef PS2_REPEAT_FILTER_EN
        expect_log("repeat", '{10'h01C, 10'h11C, 10'h01C});
`else
        expect_log("repeat", '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C});
`endif

        // Reset mid-sequence drops pending prefix and queued events.
        evt_ready = 1'b0;
        send(8'h33); send(8'hE0);
        idle(2);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        check("rst_mid_valid", 32'(evt_valid), 32'd0);
        @(posedge clk); #1;
        evt_ready = 1'b1;
        log_q.delete();
        send(8'h75);
        idle(4);
        expect_log("rst_mid_prefix", '{10'h075});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
